// File: rtl/sram_controller_pkg.sv
// Shared configuration for the 16-bit asynchronous SRAM controller:
// FSM state encoding, default geometry and the request address mapping.
package sram_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } sram_state_t;

  localparam logic [31:0] DEFAULT_BASE_ADDR   = 32'd1024;
  localparam int          DEFAULT_SRAM_AW     = 18;
  localparam int          DEFAULT_HALF_CYCLES = 2;
  localparam int          SRAM_DW             = 16;

  // Byte address to 32-bit word offset from the SRAM window base; wraps below base.
  function automatic logic [31:0] word_offset(input logic [31:0] addr,
                                              input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Counts the cycles of one 16-bit half-access; last marks the final cycle of a phase.
module sram_wait_counter
  import sram_controller_pkg::*;
#(
  parameter int HALF_CYCLES = DEFAULT_HALF_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic last
);

  localparam int CW = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  assign last = (count == CW'(HALF_CYCLES - 1));

endmodule

// File: rtl/sram_controller.sv
// Splits 32-bit word requests into two 16-bit SRAM accesses (low half first)
// and drives the asynchronous SRAM pins, including the shared data bus.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int          HALF_CYCLES = DEFAULT_HALF_CYCLES,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          SRAM_AW     = DEFAULT_SRAM_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  input  logic               read_en,
  input  logic               write_en,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N
);

  localparam bit SINGLE_CYCLE = (HALF_CYCLES == 1);

  sram_state_t        state;
  logic               is_write;
  logic [SRAM_AW-2:0] word_idx;
  logic [15:0]        wdata_hi;
  logic               dq_oe;
  logic [SRAM_DW-1:0] dq_out;
  logic               start;
  logic               in_phase;
  logic               last;
  logic [31:0]        offset;
  logic               unused_offset;

  assign offset        = word_offset(address, BASE_ADDR);
  assign unused_offset = ^offset[31:SRAM_AW-1];
  assign start         = read_en | write_en;
  assign in_phase      = (state == ST_LOW) | (state == ST_HIGH);

  sram_wait_counter #(
    .HALF_CYCLES(HALF_CYCLES)
  ) u_wait (
    .clk   (clk),
    .rst   (rst),
    .clear (~in_phase | last),
    .enable(in_phase),
    .last  (last)
  );

  // Pins for the next phase are loaded on the edge that enters it, so the SRAM
  // sees address, chip enable and data stable for the whole phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      is_write  <= 1'b0;
      word_idx  <= '0;
      wdata_hi  <= '0;
      read_data <= '0;
      SRAM_ADDR <= '0;
      SRAM_CE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      dq_oe     <= 1'b0;
      dq_out    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_LOW;
            is_write  <= write_en;
            word_idx  <= offset[SRAM_AW-2:0];
            wdata_hi  <= write_data[31:16];
            SRAM_ADDR <= {offset[SRAM_AW-2:0], 1'b0};
            SRAM_CE_N <= 1'b0;
            SRAM_OE_N <= write_en;
            dq_oe     <= write_en;
            dq_out    <= write_data[15:0];
          end
        end
        ST_LOW: begin
          if (last) begin
            state     <= ST_HIGH;
            SRAM_ADDR <= {word_idx, 1'b1};
            dq_out    <= wdata_hi;
            if (!is_write) begin
              read_data[15:0] <= SRAM_DQ;
            end
          end
        end
        ST_HIGH: begin
          if (last) begin
            state     <= ST_DONE;
            SRAM_CE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            dq_oe     <= 1'b0;
            if (!is_write) begin
              read_data[31:16] <= SRAM_DQ;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // WE_N releases on the last phase cycle so data is held past the write strobe edge.
  assign SRAM_WE_N = ~(dq_oe & (~last | SINGLE_CYCLE));
  assign SRAM_DQ   = dq_oe ? dq_out : 'z;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign ready     = (state == ST_DONE) | ((state == ST_IDLE) & ~start);

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Sits directly downstream of the memory-stage cache controller and owns the off-chip 16-bit asynchronous SRAM.
- Accepts 32-bit word read/write requests (address, write data, read_en/write_en) and splits each into two 16-bit SRAM accesses, low half first, then high half.
- Returns the assembled 32-bit read data with a one-cycle ready pulse.
- Drives the SRAM pins, including the bidirectional data bus.

Parameters:
HALF_CYCLES, 2, cycles each 16-bit half-access occupies (legal >= 1)
BASE_ADDR, 1024, byte address mapped to SRAM word 0
SRAM_AW, 18, SRAM address pin width (16-bit word granularity)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
address  input  32  byte address of request (word aligned, bits[1:0] ignored)
write_data  input  32  store data
read_en  input  1  read request, level, held by requester until ready
write_en  input  1  write request, level, held until ready
read_data  output  32  registered read result
ready  output  1  completion / idle indication
SRAM_ADDR  output  SRAM_AW  halfword address
SRAM_DQ  inout  16  data bus
SRAM_WE_N  output  1  write enable, active low
SRAM_OE_N  output  1  output enable, active low
SRAM_CE_N  output  1  chip enable, active low
SRAM_UB_N  output  1  upper byte enable, tied 0
SRAM_LB_N  output  1  lower byte enable, tied 0

Behaviour:
- States: IDLE, LOW, HIGH, DONE.
- Reset (rst=0, async):
  - state IDLE, counter 0, read_data 0.
  - WE_N=1, OE_N=1, CE_N=1, SRAM_ADDR 0, DQ high-Z; takes effect immediately, also mid-access.
  - Aborted write may leave that word partially written; no recovery is attempted.
- Request capture (IDLE, read_en|write_en at rising edge):
  - latch op, word index = (address - BASE_ADDR) >> 2 (unsigned, truncated to SRAM_AW-1 bits), and write_data.
  - Go to LOW.
  - Input changes after capture are ignored until DONE.
- Both enables high in IDLE: write wins; read_en is ignored for that access.
- LOW and HIGH phases:
  - SRAM_ADDR = {index, 0} in LOW and {index, 1} in HIGH.
  - Each phase lasts exactly HALF_CYCLES cycles; the counter resets on phase entry.
  - CE_N=0 in LOW and HIGH; CE_N=1 in IDLE and DONE.
  - Write: DQ driven with write_data[15:0] in LOW and [31:16] in HIGH for the whole phase. WE_N=0 in every phase cycle except the last (with HALF_CYCLES=1, WE_N=0 for that single cycle). OE_N=1.
  - Read: OE_N=0, DQ high-Z, WE_N=1. DQ is sampled on the last cycle of each phase into read_data[15:0] and read_data[31:16] respectively.
- DONE: lasts one cycle, ready=1, read_data stable and valid; next state IDLE.
- ready = (state==DONE) | (state==IDLE & ~read_en & ~write_en), combinational. Low in IDLE while a request is pending and in LOW/HIGH.
- Latency: enable first high in IDLE cycle 0 gives ready in cycle 2*HALF_CYCLES+1 (5 at default).
- Back-to-back: enable still high in the cycle after DONE is a new request, captured at that cycle's edge. The cache line fill (address then address+4, enable held) costs 2*(2*HALF_CYCLES+2) cycles.
- read_data changes only at the half-samples of a read; writes and idle hold it.
- DQ is never driven outside a write's LOW/HIGH phase.

Decomposition:
- Shared config package holds:
  - state encoding constants (IDLE/LOW/HIGH/DONE)
  - BASE_ADDR default
  - SRAM_AW and the data width of 16
- One sub-module: sram_wait_counter.
  - Inputs: clear, enable.
  - Outputs: last (count == HALF_CYCLES-1).
  - Resets with the same async active-low rst.
- Top holds the FSM, request latches, read_data register and tristate drive.

Test Plan:
- Reset: rst=0 mid-access with write in LOW → same cycle WE_N=1, CE_N=1, OE_N=1, DQ=Z, read_data=0. After release: ready=1 with no enables.
- Write 0x1234_5678 to 1024:
  - SRAM_ADDR=0 with DQ=0x5678, then SRAM_ADDR=1 with DQ=0x1234.
  - WE_N low 1 of 2 cycles per phase.
  - ready pulses in cycle 5.
- Read back 1024 with SRAM model returning the stored halves → read_data=0x1234_5678 at ready (cycle 5). OE_N low in cycles 1-4.
- Held read_en, address 1032 then 1036 switched on ready (line fill):
  - SRAM_ADDR sequence 4,5 then 6,7.
  - Two ready pulses 6 cycles apart.
  - ready low between them.
- read_en=write_en=1 at 1028 with data 0xDEAD_BEEF → write performed (ADDR 2,3; DQ 0xBEEF, 0xDEAD), OE_N stays 1.
- HALF_CYCLES=1: read of 1024 → ready in cycle 3. Address below BASE_ADDR (1020) wraps to the top word (ADDR 0x3FFFE/0x3FFFF).
